lsu_dmem_master: RTL and testbench

//  Load/store unit: initiator side of the data-memory request/response interface.
//  - Accepts one load/store from EXU (valid/ready), issues a single-cycle memory request,

---
 rtl/lsu_dmem_master.sv | 178 +++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// ============================================================================
// Module   : lsu_dmem_master
// Purpose  : Load/store unit, initiator side of the data-memory interface.
//            One outstanding access; lane alignment, write mask, load extension.
//            Optional: LSU_MISALIGN_CHECK_EN rejects misaligned half/word access.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dmem_master #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_wen,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_skip;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [1:0]  w_off;
    logic [31:0] w_rshift;
    logic [31:0] w_load;
    logic [3:0]  w_mask4;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_misalign;

    assign w_off     = r_addr[1:0];
    assign w_rshift  = mem_rdata >> {w_off, 3'b000};
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == c_timeout);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((in_size == 2'd1) && in_addr[0]) ||
                        (in_size[1] && (in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_load = w_rshift;
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_rshift[7]}},  w_rshift[7:0]};
            2'd1:    w_load = {{16{~r_unsigned & w_rshift[15]}}, w_rshift[15:0]};
            default: w_load = w_rshift;
        endcase
    end

    // Shifting in a 4-bit vector drops lanes that fall past byte 3.
    always_comb begin
        w_mask4 = 4'hF;
        case (r_size)
            2'd0:    w_mask4 = 4'h1 << w_off;
            2'd1:    w_mask4 = 4'h3 << w_off;
            default: w_mask4 = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)                w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = r_skip ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid || w_timeout) w_state_nxt = S_RESP;
            S_RESP: if (out_ready)               w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wen      <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_skip     <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_addr     <= in_addr;
                    r_wdata    <= in_wdata;
                    r_wen      <= in_wen;
                    r_size     <= in_size;
                    r_unsigned <= in_unsigned;
                    r_rd       <= in_rd;
                    r_skip     <= w_misalign;
                    r_rdata    <= '0;
                    r_err      <= 1'b0;
                end
                S_REQ: begin
                    r_cnt <= '0;
                    if (r_skip) r_err <= 1'b1;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_rdata <= r_wen ? 32'h0 : w_load;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_valid = (r_state == S_REQ) && !r_skip;
    assign mem_wen   = mem_valid && r_wen;
    assign mem_raddr = {r_addr[31:2], 2'b00};
    assign mem_waddr = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata << {w_off, 3'b000};
    assign mem_wmask = mem_wen ? {4'b0000, w_mask4} : 8'h00;
    assign out_valid = (r_state == S_RESP);
    assign out_rdata = r_rdata;
    assign out_rd    = r_rd;
    assign out_err   = out_valid && r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
// ============================================================================
// Module   : tb_lsu_dmem_master
// Purpose  : Self-checking bench for lsu_dmem_master with a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_dmem_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, in_unsigned;
    logic [31:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic [4:0]  in_rd;
    logic        mem_valid, mem_wen, mem_rvalid;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    lsu_dmem_master #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_wen(in_wen), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_rd(in_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_err(out_err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          mv_cyc, ov_cyc;
    logic [31:0] cap_raddr, cap_waddr, cap_wdata, o_rdata;
    logic [7:0]  cap_wmask;
    logic        cap_wen, o_err;
    logic [4:0]  o_rd;
    logic        resp_en = 1'b1;
    logic [31:0] resp_data = 32'h0;

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic un);
        logic [31:0] w;
        w = d >> (off * 8);
        case (sz)
            2'd0:    return un ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'd1:    return un ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic drive_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                             input logic [1:0] sz, input logic un, input logic [4:0] rd);
        in_addr = a; in_wdata = wd; in_wen = we; in_size = sz; in_unsigned = un; in_rd = rd;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic un, input logic [4:0] rd,
                         input logic [31:0] erd, input logic eerr);
        exp_t e;
        @(negedge clk);
        drive_req(a, wd, we, sz, un, rd);
        in_valid = 1'b1;
        e.rdata = erd; e.rd = rd; e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Plays the memory (response one cycle after the request) and records
    // the cycle numbers of mem_valid and out_valid relative to acceptance.
    task automatic wait_out(input int bound);
        logic pend;
        pend = 1'b0; mv_cyc = -1; ov_cyc = -1;
        for (int cyc = 1; cyc <= bound; cyc++) begin
            @(negedge clk);
            if (mem_valid) begin
                mv_cyc = cyc; cap_raddr = mem_raddr; cap_waddr = mem_waddr;
                cap_wdata = mem_wdata; cap_wmask = mem_wmask; cap_wen = mem_wen;
                pend = resp_en;
            end
            if (out_valid) begin
                ov_cyc = cyc; o_rdata = out_rdata; o_rd = out_rd; o_err = out_err;
                break;
            end
            @(posedge clk); #1;
            mem_rvalid = pend;
            mem_rdata  = pend ? resp_data : 32'hA5A5_5A5A;
            pend = 1'b0;
        end
    endtask

    task automatic handshake();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (mem_valid !== 1'b0)  begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        total++; if (mem_wen !== 1'b0)    begin bad++; $display("FAIL reset_mem_wen got=%b exp=0", mem_wen); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_err !== 1'b0)    begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        total++; if ({mem_raddr, mem_waddr, mem_wdata, mem_wmask, out_rdata, out_rd} !== '0)
            begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h/%h/%h exp=0", mem_raddr, mem_waddr, mem_wdata, mem_wmask, out_rdata, out_rd); end
    endtask

    task automatic test_lw();
        exp_t e;
        resp_data = 32'hDEADBEEF;
        issue(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0);
        wait_out(10);
        e = sb.pop_front();
        total++; if (mv_cyc !== 1) begin bad++; $display("FAIL lw_mem_valid_cyc got=%0d exp=1", mv_cyc); end
        total++; if (cap_raddr !== 32'h8000_0004) begin bad++; $display("FAIL lw_raddr got=%h exp=80000004", cap_raddr); end
        total++; if (cap_wen !== 1'b0) begin bad++; $display("FAIL lw_wen got=%b exp=0", cap_wen); end
        total++; if (ov_cyc !== 3) begin bad++; $display("FAIL lw_out_valid_cyc got=%0d exp=3", ov_cyc); end
        total++; if ({o_rdata, o_rd, o_err} !== e)
            begin bad++; $display("FAIL lw_result got=%h/%0d/%b exp=%h/%0d/%b", o_rdata, o_rd, o_err, e.rdata, e.rd, e.err); end
        handshake();
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL lw_return_idle got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_load_ext();
        logic [31:0] addr_t[6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                   32'h8000_0002, 32'h8000_0000, 32'h8000_0000};
        logic [1:0]  size_t[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        logic        uns_t[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp_t6[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                                   32'hFFFF_80FF, 32'h0000_0001, 32'h0000_7F01};
        exp_t e;
        resp_data = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            issue(addr_t[i], 32'h0, 1'b0, size_t[i], uns_t[i], 5'(i + 1), exp_t6[i], 1'b0);
            wait_out(10);
            e = sb.pop_front();
            total++; if ({o_rdata, o_rd, o_err} !== e || ov_cyc !== 3)
                begin bad++; $display("FAIL load_ext_%0d got=%h/%0d/%b cyc%0d exp=%h/%0d/%b cyc3", i, o_rdata, o_rd, o_err, ov_cyc, e.rdata, e.rd, e.err); end
            handshake();
        end
    endtask

    task automatic test_store();
        logic [31:0] addr_t[3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0008};
        logic [31:0] wd_t[3]   = '{32'h1234_ABCD, 32'h0000_00EE, 32'hCAFE_F00D};
        logic [1:0]  size_t[3] = '{2'd1, 2'd0, 2'd2};
        logic [31:0] ewd_t[3]  = '{32'hABCD_0000, 32'h0000_EE00, 32'hCAFE_F00D};
        logic [7:0]  emk_t[3]  = '{8'h0C, 8'h02, 8'h0F};
        exp_t e;
        resp_data = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            issue(addr_t[i], wd_t[i], 1'b1, size_t[i], 1'b0, 5'(20 + i), 32'h0, 1'b0);
            wait_out(10);
            e = sb.pop_front();
            total++; if (cap_wen !== 1'b1 || cap_wdata !== ewd_t[i] || cap_wmask !== emk_t[i] || mv_cyc !== 1)
                begin bad++; $display("FAIL store_lane_%0d got=%b/%h/%h cyc%0d exp=1/%h/%h cyc1", i, cap_wen, cap_wdata, cap_wmask, mv_cyc, ewd_t[i], emk_t[i]); end
            total++; if (cap_waddr !== {addr_t[i][31:2], 2'b00})
                begin bad++; $display("FAIL store_waddr_%0d got=%h exp=%h", i, cap_waddr, {addr_t[i][31:2], 2'b00}); end
            total++; if ({o_rdata, o_rd, o_err} !== e || ov_cyc !== 3)
                begin bad++; $display("FAIL store_result_%0d got=%h/%0d/%b cyc%0d exp=%h/%0d/%b cyc3", i, o_rdata, o_rd, o_err, ov_cyc, e.rdata, e.rd, e.err); end
            handshake();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   unstable = 0;
        resp_data = 32'h1234_5678;
        out_ready = 1'b0;
        issue(32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 5'd3, 32'h1234_5678, 1'b0);
        wait_out(10);
        e = sb.pop_front();
        total++; if ({o_rdata, o_rd, o_err} !== e || ov_cyc !== 3)
            begin bad++; $display("FAIL stall_result got=%h/%0d/%b exp=%h/%0d/%b", o_rdata, o_rd, o_err, e.rdata, e.rd, e.err); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_req(32'h8000_0020, 32'hFFFF_FFFF, 1'b1, 2'd2, 1'b0, 5'd30);
            in_valid = 1'b1;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_rdata !== e.rdata || out_rd !== e.rd ||
                out_err !== 1'b0 || in_ready !== 1'b0 || mem_valid !== 1'b0) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold got=%0d_bad_cycles exp=0", unstable); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_valid !== 1'b0)
            begin bad++; $display("FAIL stall_release got=%b%b%b exp=010", out_valid, in_ready, mem_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        resp_data = 32'h0BAD_F00D;
        issue(32'h8000_0100, 32'h0, 1'b0, 2'd2, 1'b0, 5'd11, 32'h0BAD_F00D, 1'b0);
        wait_out(10);
        e = sb.pop_front();
        total++; if ({o_rdata, o_rd, o_err} !== e)
            begin bad++; $display("FAIL b2b_first got=%h/%0d exp=%h/%0d", o_rdata, o_rd, e.rdata, e.rd); end
        drive_req(32'h8000_0104, 32'h0, 1'b0, 2'd1, 1'b1, 5'd12);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || mem_valid !== 1'b0)
            begin bad++; $display("FAIL b2b_accept_slot got=%b%b exp=10", in_ready, mem_valid); end
        e.rdata = 32'h0000_F00D; e.rd = 5'd12; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(10);
        e = sb.pop_front();
        total++; if ({o_rdata, o_rd, o_err} !== e || mv_cyc !== 1 || ov_cyc !== 3)
            begin bad++; $display("FAIL b2b_second got=%h/%0d/%b cyc%0d/%0d exp=%h/%0d/%b cyc1/3", o_rdata, o_rd, o_err, mv_cyc, ov_cyc, e.rdata, e.rd, e.err); end
        handshake();
    endtask

    task automatic test_timeout();
        exp_t e;
        resp_en = 1'b0;
        issue(32'h8000_0200, 32'h0, 1'b0, 2'd2, 1'b0, 5'd9, 32'h0, 1'b1);
        wait_out(TO + 10);
        e = sb.pop_front();
        total++; if (ov_cyc !== TO + 2) begin bad++; $display("FAIL timeout_cyc got=%0d exp=%0d", ov_cyc, TO + 2); end
        total++; if ({o_rdata, o_rd, o_err} !== e)
            begin bad++; $display("FAIL timeout_result got=%h/%0d/%b exp=%h/%0d/%b", o_rdata, o_rd, o_err, e.rdata, e.rd, e.err); end
        handshake();
        resp_en = 1'b1;
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge clk);
        drive_req(32'h8000_0300, 32'h0, 1'b0, 2'd2, 1'b0, 5'd13);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL rst_abort_idle got=%b%b exp=10", in_ready, out_valid); end
        @(posedge clk); #1 mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_abort_no_out got=%0d exp=0", seen); end
    endtask

    task automatic test_misalign();
        exp_t e;
        resp_data = 32'h1122_3344;
`ifdef LSU_MISALIGN_CHECK_EN
        issue(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 5'd14, 32'h0, 1'b1);
        wait_out(10);
        total++; if (mv_cyc !== -1 || ov_cyc !== 2)
            begin bad++; $display("FAIL misalign_timing got=%0d/%0d exp=-1/2", mv_cyc, ov_cyc); end
`else
        issue(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 5'd14, 32'h0011_2233, 1'b0);
        wait_out(10);
        total++; if (mv_cyc !== 1 || ov_cyc !== 3 || cap_raddr !== 32'h8000_0000)
            begin bad++; $display("FAIL misalign_timing got=%0d/%0d/%h exp=1/3/80000000", mv_cyc, ov_cyc, cap_raddr); end
`endif
        e = sb.pop_front();
        total++; if ({o_rdata, o_rd, o_err} !== e)
            begin bad++; $display("FAIL misalign_result got=%h/%0d/%b exp=%h/%0d/%b", o_rdata, o_rd, o_err, e.rdata, e.rd, e.err); end
        handshake();
    endtask

    task automatic test_random();
        exp_t        e;
        logic [31:0] a, wd;
        logic [1:0]  sz, off;
        logic        we, un;
        logic [3:0]  mk;
        for (int i = 0; i < 12; i++) begin
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            un  = 1'($urandom_range(0, 1));
            off = 2'($urandom_range(0, 3));
            if (sz == 2'd1) off[0] = 1'b0;
            if (sz[1])      off = 2'b00;
            a  = {$urandom_range(0, 32'h3FFF_FFFF), off};
            wd = $urandom;
            resp_data = $urandom;
            issue(a, wd, we, sz, un, 5'(i), we ? 32'h0 : m_load(resp_data, off, sz, un), 1'b0);
            wait_out(10);
            e = sb.pop_front();
            mk = (sz == 2'd0) ? 4'b0001 << off : (sz == 2'd1) ? 4'b0011 << off : 4'b1111;
            total++; if ({o_rdata, o_rd, o_err} !== e || ov_cyc !== 3)
                begin bad++; $display("FAIL rand_result_%0d got=%h/%0d/%b exp=%h/%0d/%b", i, o_rdata, o_rd, o_err, e.rdata, e.rd, e.err); end
            if (we) begin
                total++; if (cap_wdata !== (wd << (off * 8)) || cap_wmask !== {4'h0, mk})
                    begin bad++; $display("FAIL rand_store_%0d got=%h/%h exp=%h/%h", i, cap_wdata, cap_wmask, wd << (off * 8), {4'h0, mk}); end
            end
            handshake();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        drive_req(32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0);
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        test_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
